// File: rtl/mem_block_read_arbiter_if.sv
// Shared memory-side types and the block-read arbiter port bundle.
// Requester ports and the word-read memory bus travel together.
package sys;
  localparam int addr_width = 32;
  localparam int mem_block_size = 16;

  typedef struct packed {
    logic                  en;
    logic [addr_width-1:0] addr;
  } mem_read_block_req_t;

  typedef struct packed {
    logic                           done;
    logic [mem_block_size-1:0][7:0] data;
  } mem_read_block_rsp_t;
endpackage

interface mem_block_read_arbiter_if #(
  parameter int port_cnt   = 2,
  parameter int word_bytes = 4
);
  import sys::*;

  mem_read_block_req_t         mem_req [port_cnt];
  mem_read_block_rsp_t         mem_rsp [port_cnt];
  logic                        bus_req_valid;
  logic [addr_width-1:0]       bus_req_addr;
  logic                        bus_req_ready;
  logic                        bus_rsp_valid;
  logic [8*word_bytes-1:0]     bus_rsp_data;

  modport master (
    input  mem_req,
    output mem_rsp,
    output bus_req_valid,
    output bus_req_addr,
    input  bus_req_ready,
    input  bus_rsp_valid,
    input  bus_rsp_data
  );

  modport slave (
    output mem_req,
    input  mem_rsp,
    input  bus_req_valid,
    input  bus_req_addr,
    output bus_req_ready,
    output bus_rsp_valid,
    output bus_rsp_data
  );
endinterface

// File: rtl/mem_block_read_arbiter.sv
// Round-robin block-read arbiter: one block in flight,
// served as a burst of pipelined word reads on one bus.
module mem_block_read_arbiter
  import sys::*;
#(
  parameter int port_cnt    = 2,
  parameter int block_bytes = sys::mem_block_size,
  parameter int word_bytes  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  mem_block_read_arbiter_if.master bus
);

  localparam int words = block_bytes / word_bytes;
  localparam int cnt_w = $clog2(words) + 1;
  localparam int idx_w = (words > 1) ? $clog2(words) : 1;
  localparam int ptr_w = (port_cnt > 1) ? $clog2(port_cnt) : 1;
  localparam int ws    = $clog2(word_bytes);
  localparam int aw    = addr_width;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ptr_w-1:0] rr_ptr, rr_n;
  logic [ptr_w-1:0] grant, grant_n;
  logic [ptr_w-1:0] pick;
  logic             found;
  logic [aw-1:0]    base, base_n;
  logic [cnt_w-1:0] issue_cnt, recv_cnt;
  logic             abort, abort_n;
  logic             issue, recv, last;
  logic [port_cnt-1:0] done;
  logic [words-1:0][8*word_bytes-1:0] buffer;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < port_cnt; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= port_cnt) idx = idx - port_cnt;
      if (!found && bus.mem_req[ptr_w'(idx)].en) begin
        found = 1'b1;
        pick  = ptr_w'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    base_n  = base;
    rr_n    = rr_ptr;
    abort_n = abort;
    issue   = 1'b0;
    recv    = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = XFER;
          grant_n = pick;
          base_n  = bus.mem_req[pick].addr
                  & ~aw'(block_bytes - 1);
          abort_n = 1'b0;
        end
      end
      XFER: begin
        issue = (issue_cnt < cnt_w'(words))
              && bus.bus_req_ready;
        recv  = bus.bus_rsp_valid
              && (recv_cnt < cnt_w'(words));
        last  = recv
              && (recv_cnt == cnt_w'(words - 1));
        if (!bus.mem_req[grant].en) abort_n = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        if (grant == ptr_w'(port_cnt - 1))
          rr_n = '0;
        else
          rr_n = grant + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      abort     <= 1'b0;
      done      <= '0;
      buffer    <= '0;
    end else if (en) begin
      state  <= state_n;
      rr_ptr <= rr_n;
      grant  <= grant_n;
      base   <= base_n;
      abort  <= abort_n;
      done   <= '0;
      if (last && !abort_n) done[grant] <= 1'b1;
      if (state == IDLE) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (recv) begin
          buffer[recv_cnt[idx_w-1:0]] <= bus.bus_rsp_data;
          recv_cnt <= recv_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.bus_req_valid = en && (state == XFER)
                           && (issue_cnt < cnt_w'(words));
  assign bus.bus_req_addr  = base + (aw'(issue_cnt) << ws);

  always_comb begin
    for (int i = 0; i < port_cnt; i++) begin
      bus.mem_rsp[i].done = done[i];
      bus.mem_rsp[i].data = buffer;
    end
  end

endmodule

// File: tb/tb_mem_block_read_arbiter.sv
// Bench for mem_block_read_arbiter: random memory/requesters
// checked cycle by cycle against a transaction-level model.
module tb_mem_block_read_arbiter;
  import sys::*;

  localparam int PC = 2;
  localparam int BB = 16;
  localparam int WB = 4;
  localparam int W  = BB / WB;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  mem_block_read_arbiter_if #(.port_cnt(PC), .word_bytes(WB)) bif();

  mem_block_read_arbiter #(
    .port_cnt(PC), .block_bytes(BB), .word_bytes(WB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bif)
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit          want [PC];
  bit          drop [PC];
  logic [31:0] raddr [PC];
  bit g_en, g_rst, stray;
  int rmode, lat_lo, lat_hi;

  beat_t pend [$];
  int    last_due;

  int phase, mgrant, rr, issued, recvd;
  bit aborted;
  logic [31:0] mbase;
  logic [BB*8-1:0] exp_buf;

  bit p_acc, p_rspv, p_en, p_rst, p_any;
  bit p_req [PC];
  logic [31:0] p_addr;

  int grants [$];
  int done_cyc, first_cyc, acc_total, done_total;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [BB*8-1:0] blockf(logic [31:0] b);
    logic [BB*8-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r[32*k +: 32] = memf(b + 32'(4 * k));
    return r;
  endfunction

  function automatic int scan(int r, bit req [PC]);
    for (int k = 0; k < PC; k++)
      if (req[(r + k) % PC]) return (r + k) % PC;
    return -1;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit ev, ed, dn;
    int g, lat, due;
    @(posedge clk);
    cyc++;
    #1;
    // what the last edge did, in transaction terms
    if (p_rst) begin
      phase = 0; rr = 0; exp_buf = '0;
      pend.delete(); last_due = 0;
    end else if (p_en) begin
      if (phase == 3) phase = 0;
      else if (phase == 2) begin
        phase = 3;
        rr = (mgrant + 1) % PC;
      end
      if (p_acc) acc_total++;
      if (phase == 1) begin
        if (p_acc) begin
          issued++;
          lat = int'($urandom_range(lat_hi, lat_lo));
          due = cyc - 1 + lat;
          if (due <= last_due) due = last_due + 1;
          pend.push_back('{d: memf(p_addr), due: due});
          last_due = due;
        end
        if (!p_req[mgrant]) aborted = 1'b1;
        if (p_rspv) begin
          recvd++;
          if (recvd == W) begin
            phase = 2;
            exp_buf = blockf(mbase);
          end
        end
      end
    end
    // drive inputs for this cycle
    for (int i = 0; i < PC; i++) begin
      if (drop[i]) begin want[i] = 1'b0; drop[i] = 1'b0; end
      bif.mem_req[i].en   = want[i];
      bif.mem_req[i].addr = raddr[i];
    end
    en  = g_en;
    rst = g_rst;
    if (g_rst) begin pend.delete(); last_due = 0; end
    case (rmode)
      0: bif.bus_req_ready = 1'b1;
      1: bif.bus_req_ready = (cyc % 3 == 0);
      2: bif.bus_req_ready = 1'($urandom_range(1, 0));
      default: bif.bus_req_ready = (pend.size() < 3);
    endcase
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_data  = $urandom;
    if (!g_rst && g_en && pend.size() > 0 && pend[0].due <= cyc) begin
      bif.bus_rsp_valid = 1'b1;
      bif.bus_rsp_data  = pend[0].d;
      void'(pend.pop_front());
    end else if (stray && !g_rst
                 && (phase == 3 || (phase == 0 && !p_any))) begin
      bif.bus_rsp_valid = 1'b1;
    end
    #1;
    // check outputs against the model
    if (phase == 0) ev = p_en && !p_rst && p_any;
    else if (phase == 1) ev = (issued < W);
    else ev = 1'b0;
    ev = ev && g_en;
    chk("valid", bif.bus_req_valid, ev);
    if (phase == 0 && ev && bif.bus_req_valid) begin
      g = scan(rr, p_req);
      chk("pick_exists", g >= 0, 1);
      if (g >= 0) begin
        mgrant = g;
        mbase  = raddr[g] & ~32'(BB - 1);
        phase  = 1; issued = 0; recvd = 0; aborted = 1'b0;
        grants.push_back(g);
        first_cyc = cyc;
      end
    end
    if (phase == 1 && bif.bus_req_valid)
      chk("addr", bif.bus_req_addr, mbase + 32'(4 * issued));
    for (int i = 0; i < PC; i++) begin
      ed = (phase == 2) && (i == mgrant) && !aborted;
      dn = bif.mem_rsp[i].done;
      chk("done", dn, ed);
      if (dn) begin drop[i] = 1'b1; done_total++; done_cyc = cyc; end
      if (phase != 1) chk("data", bif.mem_rsp[i].data, exp_buf);
    end
    // sample what the next edge will see
    p_acc  = bif.bus_req_valid && bif.bus_req_ready;
    p_addr = bif.bus_req_addr;
    p_rspv = bif.bus_rsp_valid;
    p_en   = en;
    p_rst  = rst;
    p_any  = 1'b0;
    for (int i = 0; i < PC; i++) begin
      p_req[i] = bif.mem_req[i].en;
      p_any    = p_any || p_req[i];
    end
  endtask

  task automatic wait_idle(int maxc);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < maxc) begin
      step();
      n++;
      busy = (phase != 0);
      for (int i = 0; i < PC; i++) busy = busy || want[i];
    end
    chk("idle_timeout", n < maxc, 1);
    step();
  endtask

  task automatic wait_issued(int cnt, int maxc);
    int n;
    n = 0;
    while (!(phase == 1 && issued >= cnt) && n < maxc) begin
      step();
      n++;
    end
    chk("issue_timeout", n < maxc, 1);
  endtask

  task automatic pulse_rst();
    g_rst = 1'b1;
    step();
    g_rst = 1'b0;
    step();
  endtask

  initial begin
    int t0, a0, d0, p;
    for (int i = 0; i < PC; i++) begin
      want[i] = 1'b0; drop[i] = 1'b0; raddr[i] = '0;
      p_req[i] = 1'b0;
      bif.mem_req[i].en = 1'b0;
      bif.mem_req[i].addr = '0;
    end
    rst = 1'b1; en = 1'b1;
    bif.bus_req_ready = 1'b1;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_data = '0;
    g_en = 1'b1; g_rst = 1'b1; stray = 1'b0;
    rmode = 0; lat_lo = 1; lat_hi = 1;
    phase = 0; rr = 0; exp_buf = '0; last_due = 0;
    p_rst = 1'b1; p_en = 1'b1; p_any = 1'b0;
    p_acc = 1'b0; p_rspv = 1'b0; p_addr = '0;
    acc_total = 0; done_total = 0; done_cyc = 0; first_cyc = 0;

    repeat (3) step();
    g_rst = 1'b0;
    repeat (2) step();

    // single request, ideal memory: fixed latency
    raddr[0] = 32'h0000_1234;
    want[0]  = 1'b1;
    t0 = cyc + 1;
    wait_idle(60);
    chk("first_issue_cycle", first_cyc, t0 + 1);
    chk("done_cycle", done_cyc, t0 + W + 2);

    // round-robin rotation
    pulse_rst();
    grants.delete();
    raddr[0] = 32'h0000_4000; raddr[1] = 32'h0000_8010;
    want[0] = 1'b1; want[1] = 1'b1;
    wait_idle(100);
    raddr[0] = 32'h0000_4420;
    want[0] = 1'b1;
    wait_idle(60);
    raddr[0] = 32'h0000_5000; raddr[1] = 32'h0000_9030;
    want[0] = 1'b1; want[1] = 1'b1;
    wait_idle(100);
    chk("rr_n", grants.size(), 5);
    if (grants.size() == 5) begin
      chk("rr0", grants[0], 0);
      chk("rr1", grants[1], 1);
      chk("rr2", grants[2], 0);
      chk("rr3", grants[3], 1);
      chk("rr4", grants[4], 0);
    end

    // backpressure 1,0,0 pattern
    rmode = 1;
    a0 = acc_total;
    raddr[1] = 32'h0001_2348;
    want[1] = 1'b1;
    wait_idle(100);
    chk("bp_accepts", acc_total - a0, W);

    // variable latency, limited outstanding, stray beats while idle
    rmode = 3; lat_lo = 1; lat_hi = 5; stray = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < PC; i++) begin
        raddr[i] = {$urandom} & 32'h00FF_FFFF;
        want[i]  = ($urandom_range(1, 0) == 1) || (i == r % PC);
      end
      if (r % 2 == 1) rmode = 2; else rmode = 3;
      wait_idle(300);
      repeat (2) step();
    end
    stray = 1'b0;

    // abort: port 1 withdraws after two words issued
    rmode = 0; lat_lo = 1; lat_hi = 2;
    d0 = done_total;
    a0 = acc_total;
    raddr[1] = 32'h0002_0000;
    want[1] = 1'b1;
    wait_issued(2, 40);
    want[1] = 1'b0;
    wait_idle(60);
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_accepts", acc_total - a0, W);
    raddr[0] = 32'h0003_0040;
    want[0] = 1'b1;
    wait_idle(60);
    chk("after_abort_done", done_total - d0, 1);

    // global enable low mid-burst
    raddr[0] = 32'h0004_0080;
    want[0] = 1'b1;
    wait_issued(1, 40);
    g_en = 1'b0;
    repeat (3) step();
    g_en = 1'b1;
    wait_idle(60);

    // reset mid-transfer, request still held afterwards
    d0 = done_total;
    raddr[0] = 32'h0005_00C0;
    want[0] = 1'b1;
    wait_issued(2, 40);
    g_rst = 1'b1;
    step();
    g_rst = 1'b0;
    step();
    chk("rst_valid", bif.bus_req_valid, 0);
    p = 0;
    for (int i = 0; i < PC; i++) p += int'(bif.mem_rsp[i].done);
    chk("rst_done", p, 0);
    wait_idle(60);
    chk("rst_reserve", done_total - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
